win_screen_ctrl: RTL and testbench
==================================

# win_screen_ctrl

Sequencer for the end-of-game overlay: latches the first king-capture event, drives the `white_win`/`black_win` selects of the win-overlay stage, and holds them for a minimum number of frames. All overlay changes are applied only at frame boundaries, so the picture never tears. The block freezes game input while the overlay is shown and issues a one-cycle board reset when play resumes. It sits between the game-logic core and the VGA overlay stage, in the pixel-clock domain.

## Interface
Parameters:
- MIN_SHOW_FRAMES, default 120: frames the overlay must be shown before a restart is accepted (about 2 s at 60 Hz).
- AUTO_CLEAR_FRAMES, default 0: frames after which the overlay clears without a restart; 0 disables auto-clear.
- FRAME_CNT_W, default 12: width of the frame counter.

Ports (reset rst, synchronous, active-high; clock clk):
- clk  in  1  pixel clock.
- rst  in  1  synchronous active-high reset.
- vblnk  in  1  vertical blank from the timing chain; its rising edge is the frame tick.
- white_king_taken  in  1  one-cycle pulse from game logic; black wins.
- black_king_taken  in  1  one-cycle pulse from game logic; white wins.
- restart_btn  in  1  debounced level; only its rising edge is used.
- white_win  out  1  overlay select, white victory.
- black_win  out  1  overlay select, black victory.
- game_freeze  out  1  high while game input must be ignored.
- board_reset  out  1  one-cycle pulse that reinitialises the board.

## Operation
- `frame_tick` = vblnk & ~vblnk_q.
- `restart_rise` = restart_btn & ~restart_q.
- States: PLAY, PENDING, SHOW, CLEAR. The state register resets to PLAY.

State transitions:
- PLAY: on either capture pulse, latch the winner in `winner_q` and go to PENDING.
  - white victory = black_king_taken; black victory = white_king_taken.
  - If both pulses arrive in the same cycle, white victory wins.
- PENDING: on `frame_tick`, set white_win or black_win from `winner_q`, clear `frame_cnt`, and go to SHOW. Capture pulses and restart are ignored.
- SHOW: `frame_cnt` increments on each `frame_tick` and saturates at all-ones. Go to CLEAR when either condition holds:
  - `restart_rise` and `frame_cnt` ≥ MIN_SHOW_FRAMES, or
  - AUTO_CLEAR_FRAMES ≠ 0 and `frame_cnt` ≥ AUTO_CLEAR_FRAMES.
  - A restart edge arriving before the minimum is discarded; it is not queued.
- CLEAR: on `frame_tick`, drop white_win/black_win, pulse board_reset, and go to PLAY.

Outputs:
- game_freeze = (state ≠ PLAY), registered.
- white_win and black_win are never high together.
- Capture pulses received in any state other than PLAY are ignored.

## Timing
- Reset value of every output is 0. Internally: state = PLAY, `winner_q` = 0, `frame_cnt` = 0, `vblnk_q` = 0, `restart_q` = 0.
- All outputs are registered.
- game_freeze rises 1 cycle after the capture pulse.
- A capture pulse in cycle t enters PENDING at t+1. The win output rises 1 cycle after the first `frame_tick` sampled in PENDING.
  - A `frame_tick` in the same cycle as the capture pulse does not count; the block waits for the next frame.
- The CLEAR exit is a single cycle, 1 cycle after the `frame_tick`, in which all of the following happen: win outputs fall, board_reset = 1, game_freeze falls.
- board_reset is high for exactly one cycle.
- A `restart_rise` in the same cycle as a `frame_tick` uses the pre-increment `frame_cnt`.
- Reset mid-operation (any state): all outputs go to 0 on the next cycle and board_reset is not pulsed.

## Structure
- `game_pkg` holds:
  - `win_state_t` (enum PLAY, PENDING, SHOW, CLEAR);
  - `winner_t` (enum WHITE, BLACK);
  - localparam `FRAME_CNT_W_DEF` = 12.
- One sub-module, `rise_detect` (clk, rst, d, rise), instantiated twice: once for vblnk and once for restart_btn.
- The FSM, frame counter and output registers live in the top level.

## Test plan
- Reset, then a black_king_taken pulse at cycle 100 with vblnk rising at cycle 500: game_freeze = 1 at cycle 101; white_win = 1 at cycle 501; black_win stays 0.
- Both capture pulses in the same cycle: only white_win asserts. A further black_king_taken pulse during SHOW changes nothing.
- With MIN_SHOW_FRAMES = 4: restart edge after 2 frames is ignored, and the overlay stays. Restart edge after 5 frames, with the next vblnk rise at cycle T: at T+1, white_win = 0, board_reset is a single-cycle 1, and game_freeze = 0.
- With AUTO_CLEAR_FRAMES = 3 and no restart: the overlay clears 1 cycle after the 4th frame tick following entry to SHOW, with board_reset pulsed.
- Capture pulse coincident with a vblnk rise: the win output waits for the following vblnk rise.
- rst asserted during SHOW: all outputs are 0 the next cycle, there is no board_reset pulse, and a new capture pulse is then accepted normally.

Source files
------------

// File: rtl/win_screen_ctrl_pkg.sv
// rtl/win_screen_ctrl_pkg.sv - shared types for the end-of-game overlay sequencer
package game_pkg;

  typedef enum logic [1:0] {
    PLAY    = 2'd0,
    PENDING = 2'd1,
    SHOW    = 2'd2,
    CLEAR   = 2'd3
  } win_state_t;

  typedef enum logic {
    WHITE = 1'b0,
    BLACK = 1'b1
  } winner_t;

  localparam int FRAME_CNT_W_DEF = 12;

endpackage

// File: rtl/win_screen_ctrl_if.sv
// rtl/win_screen_ctrl_if.sv - game/timing side signals of the win overlay sequencer
interface win_screen_ctrl_if;
  logic vblnk;
  logic white_king_taken;
  logic black_king_taken;
  logic restart_btn;
  logic white_win;
  logic black_win;
  logic game_freeze;
  logic board_reset;

  modport master (
    output vblnk, white_king_taken, black_king_taken, restart_btn,
    input  white_win, black_win, game_freeze, board_reset
  );

  modport slave (
    input  vblnk, white_king_taken, black_king_taken, restart_btn,
    output white_win, black_win, game_freeze, board_reset
  );
endinterface

// File: rtl/win_screen_ctrl_rise_detect.sv
// rtl/win_screen_ctrl_rise_detect.sv - rising-edge detector on a level input
module rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic d_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      d_q <= 1'b0;
    end else begin
      d_q <= d;
    end
  end

  assign rise = d & ~d_q;

endmodule

// File: rtl/win_screen_ctrl.sv
// rtl/win_screen_ctrl.sv - latches the first king capture and sequences the win overlay
// on frame boundaries, freezing play and pulsing a board reset on resume.
module win_screen_ctrl
  import game_pkg::*;
#(
  parameter int MIN_SHOW_FRAMES   = 120,
  parameter int AUTO_CLEAR_FRAMES = 0,
  parameter int FRAME_CNT_W       = FRAME_CNT_W_DEF
) (
  input  logic clk,
  input  logic rst,
  win_screen_ctrl_if.slave bus
);

  localparam logic [FRAME_CNT_W-1:0] MIN_CNT  = FRAME_CNT_W'(MIN_SHOW_FRAMES);
  localparam logic [FRAME_CNT_W-1:0] AUTO_CNT = FRAME_CNT_W'(AUTO_CLEAR_FRAMES);
  localparam bit                     AUTO_EN  = (AUTO_CLEAR_FRAMES != 0);

  logic frame_tick;
  logic restart_rise;

  win_state_t             state_q;
  winner_t                winner_q;
  logic [FRAME_CNT_W-1:0] frame_cnt_q;
  logic                   white_win_q;
  logic                   black_win_q;
  logic                   game_freeze_q;
  logic                   board_reset_q;

  rise_detect u_vblnk_rise (
    .clk  (clk),
    .rst  (rst),
    .d    (bus.vblnk),
    .rise (frame_tick)
  );

  rise_detect u_restart_rise (
    .clk  (clk),
    .rst  (rst),
    .d    (bus.restart_btn),
    .rise (restart_rise)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= PLAY;
      winner_q      <= WHITE;
      frame_cnt_q   <= '0;
      white_win_q   <= 1'b0;
      black_win_q   <= 1'b0;
      game_freeze_q <= 1'b0;
      board_reset_q <= 1'b0;
    end else begin
      board_reset_q <= 1'b0;
      case (state_q)
        PLAY: begin
          // A simultaneous double capture resolves to a white victory.
          if (bus.black_king_taken || bus.white_king_taken) begin
            winner_q      <= bus.black_king_taken ? WHITE : BLACK;
            game_freeze_q <= 1'b1;
            state_q       <= PENDING;
          end
        end
        PENDING: begin
          if (frame_tick) begin
            white_win_q <= (winner_q == WHITE);
            black_win_q <= (winner_q == BLACK);
            frame_cnt_q <= '0;
            state_q     <= SHOW;
          end
        end
        SHOW: begin
          if (frame_tick && (frame_cnt_q != '1)) begin
            frame_cnt_q <= frame_cnt_q + 1'b1;
          end
          // Conditions use the pre-increment count; early restarts are dropped.
          if ((restart_rise && (frame_cnt_q >= MIN_CNT)) ||
              (AUTO_EN && (frame_cnt_q >= AUTO_CNT))) begin
            state_q <= CLEAR;
          end
        end
        CLEAR: begin
          if (frame_tick) begin
            white_win_q   <= 1'b0;
            black_win_q   <= 1'b0;
            game_freeze_q <= 1'b0;
            board_reset_q <= 1'b1;
            state_q       <= PLAY;
          end
        end
        default: begin
          state_q <= PLAY;
        end
      endcase
    end
  end

  assign bus.white_win   = white_win_q;
  assign bus.black_win   = black_win_q;
  assign bus.game_freeze = game_freeze_q;
  assign bus.board_reset = board_reset_q;

endmodule

// File: tb/tb_win_screen_ctrl.sv
// tb/tb_win_screen_ctrl.sv - directed vector bench for win_screen_ctrl
module tb_win_screen_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  win_screen_ctrl_if ifa ();
  win_screen_ctrl_if ifb ();

  assign ifb.vblnk            = ifa.vblnk;
  assign ifb.white_king_taken = ifa.white_king_taken;
  assign ifb.black_king_taken = ifa.black_king_taken;
  assign ifb.restart_btn      = ifa.restart_btn;

  win_screen_ctrl #(
    .MIN_SHOW_FRAMES   (4),
    .AUTO_CLEAR_FRAMES (0),
    .FRAME_CNT_W       (12)
  ) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa.slave)
  );

  win_screen_ctrl #(
    .MIN_SHOW_FRAMES   (4),
    .AUTO_CLEAR_FRAMES (3),
    .FRAME_CNT_W       (12)
  ) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ifb.slave)
  );

  // inputs and expected {white_win, black_win, game_freeze, board_reset} after the edge
  typedef struct packed {
    logic       r;
    logic       v;
    logic       wk;
    logic       bk;
    logic       rs;
    logic [3:0] exp;
  } vec_t;

  vec_t vecs [24];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic step(input logic r, input logic v, input logic wk,
                      input logic bk, input logic rs);
    @(negedge clk);
    rst                  = r;
    ifa.vblnk            = v;
    ifa.white_king_taken = wk;
    ifa.black_king_taken = bk;
    ifa.restart_btn      = rs;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  function automatic logic [3:0] outs_a();
    return {ifa.white_win, ifa.black_win, ifa.game_freeze, ifa.board_reset};
  endfunction

  function automatic logic [3:0] outs_b();
    return {ifb.white_win, ifb.black_win, ifb.game_freeze, ifb.board_reset};
  endfunction

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got wwbfr=%04b expected %04b", name, act, exp);
    end
  endtask

  initial begin
    // both captures, early/held restarts ignored, restart after 5 frames clears
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000};
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0010};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0010};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1010};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b1010};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b1010};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1010};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1010};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1010};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1010};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b1010};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b1010};
    vecs[13] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'b1010};
    vecs[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b1010};
    vecs[15] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'b1010};
    vecs[16] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b1010};
    vecs[17] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'b1010};
    vecs[18] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b1010};
    vecs[19] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1010};
    vecs[20] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b1010};
    vecs[21] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b1010};
    vecs[22] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0001};
    vecs[23] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000};

    rst = 1'b1;
    ifa.vblnk = 1'b0;
    ifa.white_king_taken = 1'b0;
    ifa.black_king_taken = 1'b0;
    ifa.restart_btn = 1'b0;

    for (int i = 0; i < 24; i++) begin
      step(vecs[i].r, vecs[i].v, vecs[i].wk, vecs[i].bk, vecs[i].rs);
      check($sformatf("vec%0d", i), outs_a(), vecs[i].exp);
    end

    // black king taken at cycle 100, vblnk rise at cycle 500
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("reset_state", outs_a(), 4'b0000);
    idle(99);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("freeze_c101", outs_a(), 4'b0010);
    idle(399);
    check("pending_c500", outs_a(), 4'b0010);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("white_c501", outs_a(), 4'b1010);

    // capture coincident with vblnk rise waits for the next frame
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    check("coinc_tick", outs_a(), 4'b0010);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(3);
    check("coinc_wait", outs_a(), 4'b0010);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("coinc_black", outs_a(), 4'b0110);

    // auto-clear after 3 frames on dut_b
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("auto_show", outs_b(), 4'b1010);
    for (int f = 1; f <= 3; f++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      check($sformatf("auto_tick%0d", f), outs_b(), 4'b1010);
    end
    idle(2);
    check("auto_hold", outs_b(), 4'b1010);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("auto_clear", outs_b(), 4'b0001);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("auto_pulse1", outs_b(), 4'b0000);

    // reset during SHOW, then a fresh capture is accepted
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("rst_pre", outs_a(), 4'b0110);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("rst_show", outs_a(), 4'b0000);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("rst_after", outs_a(), 4'b0000);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("rst_recapture", outs_a(), 4'b0010);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("rst_rewin", outs_a(), 4'b1010);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
